// File: rtl/accel_sample_sequencer.sv
// rtl/accel_sample_sequencer.sv - ADXL345 one-time config then periodic six-register X/Y/Z sampling
// Issues one single-byte transaction at a time over the i2c_controller start/finished handshake.
module accel_sample_sequencer #(
  parameter int unsigned SYS_CLK_SPEED  = 50000000,
  parameter int unsigned SAMPLE_RATE_HZ = 10,
  parameter logic [6:0]  ACCEL_ADDR     = 7'h1D,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic        i2c_r_w,
  output logic [7:0]  i2c_write_data,
  output logic        i2c_start,
  input  logic        i2c_ready,
  input  logic        i2c_finished,
  input  logic [7:0]  i2c_read_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned TICK_COUNT = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
  localparam int unsigned TW         = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int unsigned OW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FMT_ISSUE,
    S_FMT_WAIT,
    S_PWR_ISSUE,
    S_PWR_WAIT,
    S_WAIT_TICK,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_PUBLISH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_rd_idx;
  logic [TW-1:0]   r_tick_cnt;
  logic [OW-1:0]   r_to_cnt;
  logic            r_pending;
  logic            r_fin_d;
  logic            w_tick;
  logic            w_wait;
  logic            w_done;
  logic            w_timeout;
  logic            w_issue;
  logic [7:0]      w_tgt_reg;
  logic [7:0]      w_tgt_wdata;
  logic            w_tgt_rw;
  logic [4:0][7:0] r_buf;
  logic [7:0]      r_reg_addr;
  logic [7:0]      r_wdata;
  logic            r_rw;
  logic            r_start;
  logic            r_init_done;
  logic            r_timeout_err;
  logic [15:0]     r_x;
  logic [15:0]     r_y;
  logic [15:0]     r_z;

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_wait    = (r_state == S_FMT_WAIT) || (r_state == S_PWR_WAIT) || (r_state == S_RD_WAIT);
  // Only a fresh rising edge counts; a level left high by the previous transaction is ignored.
  assign w_done    = w_wait && i2c_finished && !r_fin_d;
  assign w_timeout = w_wait && !w_done && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FMT_ISSUE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FMT_ISSUE: if (i2c_ready) w_next = S_FMT_WAIT;
      S_FMT_WAIT: begin
        if (w_done)         w_next = S_PWR_ISSUE;
        else if (w_timeout) w_next = S_FMT_ISSUE;
      end
      S_PWR_ISSUE: if (i2c_ready) w_next = S_PWR_WAIT;
      S_PWR_WAIT: begin
        if (w_done)         w_next = S_WAIT_TICK;
        else if (w_timeout) w_next = S_FMT_ISSUE;
      end
      S_WAIT_TICK: if (w_tick || r_pending) w_next = S_RD_ISSUE;
      S_RD_ISSUE:  if (i2c_ready) w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (w_done)         w_next = (r_rd_idx == 3'd5) ? S_PUBLISH : S_RD_ISSUE;
        else if (w_timeout) w_next = S_WAIT_TICK;
      end
      S_PUBLISH:   w_next = S_WAIT_TICK;
      default:     w_next = S_FMT_ISSUE;
    endcase
  end

  always_comb begin
    w_issue     = 1'b0;
    w_tgt_reg   = 8'h00;
    w_tgt_wdata = 8'h00;
    w_tgt_rw    = 1'b0;
    case (r_state)
      S_FMT_ISSUE: begin
        w_issue     = i2c_ready;
        w_tgt_reg   = 8'h31;
        w_tgt_wdata = 8'h0B;
      end
      S_PWR_ISSUE: begin
        w_issue     = i2c_ready;
        w_tgt_reg   = 8'h2D;
        w_tgt_wdata = 8'h08;
      end
      S_RD_ISSUE: begin
        w_issue     = i2c_ready;
        w_tgt_reg   = 8'h32 + {5'd0, r_rd_idx};
        w_tgt_rw    = 1'b1;
      end
      default: ;
    endcase
    busy         = w_wait;
    sample_valid = (r_state == S_PUBLISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt    <= '0;
      r_pending     <= 1'b0;
      r_fin_d       <= 1'b0;
      r_to_cnt      <= '0;
      r_start       <= 1'b0;
      r_reg_addr    <= 8'h00;
      r_wdata       <= 8'h00;
      r_rw          <= 1'b0;
      r_rd_idx      <= 3'd0;
      r_buf         <= '0;
      r_x           <= 16'h0000;
      r_y           <= 16'h0000;
      r_z           <= 16'h0000;
      r_init_done   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_fin_d    <= i2c_finished;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

      // One tick of backlog at most; WAIT_TICK always consumes it.
      if (r_state == S_WAIT_TICK) r_pending <= 1'b0;
      else if (w_tick)            r_pending <= 1'b1;

      r_start <= w_issue;
      if (w_issue) begin
        r_reg_addr <= w_tgt_reg;
        r_wdata    <= w_tgt_wdata;
        r_rw       <= w_tgt_rw;
        r_to_cnt   <= '0;
      end else if (w_wait) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_timeout) r_timeout_err <= 1'b1;
      if ((r_state == S_PWR_WAIT) && w_done) r_init_done <= 1'b1;

      if (r_state == S_WAIT_TICK) begin
        r_rd_idx <= 3'd0;
      end else if ((r_state == S_RD_WAIT) && w_done) begin
        r_rd_idx <= r_rd_idx + 3'd1;
        // Last byte goes straight to the outputs so all three axes change with sample_valid.
        if (r_rd_idx == 3'd5) begin
          r_x <= {r_buf[1], r_buf[0]};
          r_y <= {r_buf[3], r_buf[2]};
          r_z <= {i2c_read_data, r_buf[4]};
        end else begin
          r_buf[r_rd_idx] <= i2c_read_data;
        end
      end
    end
  end

  assign i2c_dev_addr   = ACCEL_ADDR;
  assign i2c_reg_addr   = r_reg_addr;
  assign i2c_r_w        = r_rw;
  assign i2c_write_data = r_wdata;
  assign i2c_start      = r_start;
  assign accel_x        = r_x;
  assign accel_y        = r_y;
  assign accel_z        = r_z;
  assign init_done      = r_init_done;
  assign timeout_err    = r_timeout_err;

endmodule
